// File: rtl/fetch_line_ctrl.sv
// rtl/fetch_line_ctrl.sv - instruction fetch line controller feeding the 64-bit instruction buffer
//
// Owns the fetch PC, requests 8-byte-aligned lines from instruction memory
// (one outstanding request at most) and hands each returned line to the
// instruction buffer with its line address and a per-word valid mask.
// A redirect restarts fetch at a new target; a line that is already in
// flight when the redirect lands is swallowed on return.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   redirect_valid/_pc      one-cycle restart request and its target
//   mem_req/_addr           line request (combinational from state) and line address
//   mem_gnt                 memory accepted the request this cycle
//   mem_rvalid/_rdata       returned line, low word at the line address
//   out_valid/_ready        registered line handshake towards the buffer
//   out_data/_pc/_mask      line, its address, bit0 low word valid / bit1 high word valid

module fetch_line_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [31:0] out_pc,
  output logic [1:0]  out_mask
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [31:0] RESET_LINE = RESET_PC & 32'hFFFF_FFF8;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        half_q, half_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [1:0]  out_mask_q, out_mask_d;

  logic [31:0] redirect_target;
  logic [31:0] line_pc;
  logic [31:0] next_line;

  // Word-aligned target; pc keeps bit 2 so an upper-half target can be masked.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign line_pc         = pc_q & 32'hFFFF_FFF8;
  // Natural 32-bit overflow gives the wrap from the top line back to 0.
  assign next_line       = line_pc + 32'd8;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          // A grant in the redirect cycle still leaves a response to swallow.
          state_d = mem_gnt ? ST_DROP : ST_REQ;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = mem_rvalid ? ST_REQ : ST_DROP;
        end else if (mem_rvalid) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || out_ready) begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (mem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Output logic for the memory side; reset overrides so the request is
  // quiet and the address shows the reset line while reset is held.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = line_pc;
    if (reset) begin
      mem_addr = RESET_LINE;
    end else if (state_q == ST_REQ) begin
      mem_req = 1'b1;
    end
  end

  // Datapath next values
  always_comb begin
    pc_d        = pc_q;
    half_d      = half_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    out_mask_d  = out_mask_q;
    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (mem_gnt) begin
            half_d = pc_q[2];
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            out_data_d  = mem_rdata;
            out_pc_d    = line_pc;
            // Entry into the upper word leaves the low word unusable.
            out_mask_d  = half_q ? 2'b10 : 2'b11;
            out_valid_d = 1'b1;
            pc_d        = next_line;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_LINE;
      half_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_pc_q    <= 32'd0;
      out_mask_q  <= 2'b00;
    end else begin
      pc_q        <= pc_d;
      half_q      <= half_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
      out_mask_q  <= out_mask_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pc    = out_pc_q;
  assign out_mask  = out_mask_q;

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// tb/tb_fetch_line_ctrl.sv - self-checking bench for fetch_line_ctrl

module tb_fetch_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [31:0] out_pc;
  logic [1:0]  out_mask;

  logic        m2_req;
  logic [31:0] m2_addr;
  logic        m2_gnt;
  logic        m2_rvalid;
  logic [63:0] m2_rdata;
  logic        o2_valid;
  logic [63:0] o2_data;
  logic [31:0] o2_pc;
  logic [1:0]  o2_mask;
  logic        z2_redir;
  logic [31:0] z2_rpc;
  logic        z2_ready;

  fetch_line_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pc(out_pc), .out_mask(out_mask)
  );

  fetch_line_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(z2_redir), .redirect_pc(z2_rpc),
    .mem_req(m2_req), .mem_addr(m2_addr), .mem_gnt(m2_gnt),
    .mem_rvalid(m2_rvalid), .mem_rdata(m2_rdata),
    .out_valid(o2_valid), .out_ready(z2_ready), .out_data(o2_data),
    .out_pc(o2_pc), .out_mask(o2_mask)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_data(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h5EED_0000, a ^ 32'h0000_BEEF};
  endfunction

  // memory model state
  logic        outst;
  logic [31:0] oaddr;
  int          dly;
  logic [31:0] gnt_addr;
  int          gnt_wait;
  int          gnt_pct;
  int          lat_min;
  int          lat_max;
  logic        stale_en;
  logic [63:0] stale_data;
  logic        m2_pend;
  logic [31:0] m2_oaddr;
  logic [31:0] m2_gaddr;

  // reference model state (fetch stream view)
  logic        model_on;
  logic [31:0] exp_pc;
  logic [1:0]  exp_mask;
  int          accepted;

  // snapshot of pins before each edge
  logic        s_redir;
  logic [31:0] s_rpc;
  logic        s_ready;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [63:0] s_data;
  logic [1:0]  s_mask;

  task automatic mem_decide();
    if (reset) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      m2_gnt  = 1'b0; m2_rvalid  = 1'b0;
    end else begin
      mem_rvalid = outst && (dly == 0);
      mem_rdata  = stale_en ? stale_data : line_data(oaddr);
      mem_gnt    = 1'b0;
      if (mem_req) begin
        if (gnt_wait > 0) gnt_wait--;
        else mem_gnt = ($urandom_range(0, 99) < gnt_pct);
        gnt_addr = mem_addr;
      end
      m2_gnt    = m2_req;
      m2_gaddr  = m2_addr;
      m2_rvalid = m2_pend;
      m2_rdata  = line_data(m2_oaddr);
    end
  endtask

  task automatic mem_bookkeep();
    if (reset) begin
      outst = 1'b0; stale_en = 1'b0; m2_pend = 1'b0;
    end else begin
      if (mem_rvalid) begin
        outst = 1'b0; stale_en = 1'b0;
      end else if (outst && dly > 0) begin
        dly--;
      end
      if (mem_gnt) begin
        outst = 1'b1;
        oaddr = gnt_addr;
        dly   = $urandom_range(lat_min, lat_max);
      end
      m2_pend = m2_gnt;
      if (m2_gnt) m2_oaddr = m2_gaddr;
    end
  endtask

  // The buffer should see line(target), line(target)+8, ... after each
  // redirect, with only the first line after an upper-half target masked.
  task automatic model_step();
    if (s_redir) begin
      exp_pc   = s_rpc & 32'hFFFF_FFF8;
      exp_mask = s_rpc[2] ? 2'b10 : 2'b11;
    end else if (s_valid && s_ready) begin
      check_eq("rnd_pc", s_pc, exp_pc);
      check_eq("rnd_mask", s_mask, exp_mask);
      check_eq("rnd_data", s_data, line_data(exp_pc));
      exp_pc   = exp_pc + 32'd8;
      exp_mask = 2'b11;
      accepted++;
    end else if (s_valid) begin
      check_eq("rnd_hold_valid", out_valid, 1'b1);
      check_eq("rnd_hold_pc", out_pc, s_pc);
      check_eq("rnd_hold_data", out_data, s_data);
      check_eq("rnd_hold_mask", out_mask, s_mask);
    end
    check_eq("rnd_req_vs_valid", mem_req && out_valid, 1'b0);
  endtask

  task automatic cyc();
    #1;
    mem_decide();
    s_redir = redirect_valid; s_rpc = redirect_pc; s_ready = out_ready;
    s_valid = out_valid; s_pc = out_pc; s_data = out_data; s_mask = out_mask;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_bookkeep();
    if (model_on) model_step();
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin cyc(); n++; end
    if (!mem_req) check_eq(tag, 1'b0, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin cyc(); n++; end
    if (!out_valid) check_eq(tag, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, mem_req, 1'b0);
    check_eq({tag, "_addr"}, mem_addr, 32'h100);
    check_eq({tag, "_valid"}, out_valid, 1'b0);
    check_eq({tag, "_data"}, out_data, 64'd0);
    check_eq({tag, "_pc"}, out_pc, 32'd0);
    check_eq({tag, "_mask"}, out_mask, 2'b00);
  endtask

  logic [31:0] hold_pc;
  logic [63:0] hold_data;
  logic [31:0] first_addr;
  logic        got_addr;
  logic        saw_stale;
  int          rv_count;
  logic        any_valid;
  logic [63:0] stale_val;

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    m2_gnt = 1'b0; m2_rvalid = 1'b0; m2_rdata = 64'd0;
    z2_redir = 1'b0; z2_rpc = 32'd0; z2_ready = 1'b1;
    outst = 1'b0; oaddr = 32'd0; dly = 0; gnt_addr = 32'd0; gnt_wait = 0;
    gnt_pct = 100; lat_min = 0; lat_max = 0; stale_en = 1'b0; stale_data = 64'd0;
    m2_pend = 1'b0; m2_oaddr = 32'd0; m2_gaddr = 32'd0;
    model_on = 1'b0; exp_pc = 32'h100; exp_mask = 2'b11; accepted = 0;
    stale_val = 64'hDEADBEEF_CAFEF00D;

    @(negedge clk);
    repeat (3) cyc();
    check_reset_outputs("reset");
    check_eq("reset_wrap_addr", m2_addr, 32'hFFFF_FFF8);

    // release: request visible in the first cycle, then 3-cycle cadence
    reset = 1'b0;
    #1;
    check_eq("release_req", mem_req, 1'b1);
    check_eq("release_addr", mem_addr, 32'h100);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check_eq("tp_valid", out_valid, (i % 3) == 2);
      if ((i % 3) == 2) begin
        check_eq("tp_pc", out_pc, 32'h100 + 32'(8 * ((i - 2) / 3)));
        check_eq("tp_mask", out_mask, 2'b11);
        check_eq("tp_data", out_data, line_data(32'h100 + 32'(8 * ((i - 2) / 3))));
      end
      if (i == 2) begin
        check_eq("wrap_valid", o2_valid, 1'b1);
        check_eq("wrap_pc", o2_pc, 32'hFFFF_FFF8);
        check_eq("wrap_mask", o2_mask, 2'b11);
        check_eq("wrap_data", o2_data, line_data(32'hFFFF_FFF8));
      end
      if (i == 3) begin
        check_eq("wrap_next_req", m2_req, 1'b1);
        check_eq("wrap_next_addr", m2_addr, 32'h0);
      end
    end

    // back-pressure
    out_ready = 1'b0;
    wait_valid("bp_timeout");
    hold_pc = out_pc; hold_data = out_data;
    check_eq("bp_line_pc", hold_pc, 32'h118);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_pc", out_pc, hold_pc);
      check_eq("bp_data", out_data, hold_data);
      check_eq("bp_req", mem_req, 1'b0);
    end
    out_ready = 1'b1;
    cyc();
    check_eq("bp_release", out_valid, 1'b0);

    // redirect to an upper-half target while waiting, stale response follows
    lat_min = 1; lat_max = 1;
    wait_req("rdw_req_timeout");
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h204;
    stale_en = 1'b1; stale_data = stale_val;
    cyc();
    lat_min = 0; lat_max = 0;
    got_addr = 1'b0; saw_stale = 1'b0; first_addr = 32'd0;
    for (int n = 0; n < 12 && !out_valid; n++) begin
      cyc();
      if (mem_req && !got_addr) begin first_addr = mem_addr; got_addr = 1'b1; end
      if (out_valid && out_data == stale_val) saw_stale = 1'b1;
    end
    check_eq("rdw_seen", out_valid, 1'b1);
    check_eq("rdw_addr", first_addr, 32'h200);
    check_eq("rdw_pc", out_pc, 32'h200);
    check_eq("rdw_mask", out_mask, 2'b10);
    check_eq("rdw_data", out_data, line_data(32'h200));
    check_eq("rdw_stale", saw_stale, 1'b0);

    // redirect together with a grant: one response swallowed
    wait_req("sg_req_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    rv_count = 0; any_valid = 1'b0;
    for (int n = 0; n < 12 && !mem_req; n++) begin
      cyc();
      if (mem_rvalid) rv_count++;
      if (out_valid) any_valid = 1'b1;
    end
    check_eq("sg_req", mem_req, 1'b1);
    check_eq("sg_addr", mem_addr, 32'h40);
    check_eq("sg_swallowed", rv_count, 1);
    check_eq("sg_no_valid", any_valid, 1'b0);
    wait_valid("sg_valid_timeout");
    check_eq("sg_pc", out_pc, 32'h40);
    check_eq("sg_mask", out_mask, 2'b11);

    // redirect together with a HOLD handshake
    cyc();
    wait_valid("sh_valid_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cyc();
    check_eq("sh_dropped", out_valid, 1'b0);
    wait_valid("sh_next_timeout");
    check_eq("sh_next_pc", out_pc, 32'h80);

    // grant stall
    cyc();
    wait_req("gs_req_timeout");
    gnt_wait = 4;
    first_addr = mem_addr;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("gs_req", mem_req, 1'b1);
      check_eq("gs_addr", mem_addr, first_addr);
    end
    cyc();
    check_eq("gs_granted", mem_req, 1'b0);

    // reset while waiting for a response
    reset = 1'b1;
    cyc();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    #1;
    check_eq("mid_reset_req", mem_req, 1'b1);
    check_eq("mid_reset_addr", mem_addr, 32'h100);

    // randomized run against the fetch-stream model
    exp_pc = 32'h100; exp_mask = 2'b11; accepted = 0;
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    model_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else redirect_pc = 32'($urandom_range(0, 1023));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    model_on = 1'b0;
    check_eq("rnd_progress", accepted > 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
